// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - instruction memory fetch port with 2-cycle read pipeline, response queue and load port
module imem_fetch_port #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int RESP_DEPTH = 2,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [1:0]        resp_fault,
  input  logic              flush,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [1:0]        s1_fault;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] q_data  [RESP_DEPTH];
  logic [ADDR_W-1:0] q_addr  [RESP_DEPTH];
  logic [1:0]        q_fault [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              accept, push, pop;
  logic [IDX_W-1:0]  rd_idx;
  logic [1:0]        req_fault;
  logic [CNT_W:0]    occ, occ_limit;

  assign rd_idx       = req_addr[IDX_W+1:2];
  assign req_fault[0] = (req_addr[1:0] != 2'b00);
  assign req_fault[1] = ((req_addr >> 2) >= DEPTH_A);

  assign resp_valid = !flush && (count != '0);
  assign pop        = resp_valid && resp_ready;
  assign push       = s1_valid && !flush;

  // pop frees a slot in the same cycle, hence the resp_ready -> req_ready path
  assign occ       = {1'b0, count} + (CNT_W+1)'(s1_valid);
  assign occ_limit = (CNT_W+1)'(RESP_DEPTH) + (CNT_W+1)'(pop);
  assign req_ready = !flush && (occ < occ_limit);
  assign accept    = req_valid && req_ready;

  assign resp_data  = resp_valid ? q_data[rd_ptr]  : '0;
  assign resp_addr  = resp_valid ? q_addr[rd_ptr]  : '0;
  assign resp_fault = resp_valid ? q_fault[rd_ptr] : 2'b00;

  // Storage is never reset; nonblocking read and write give read-first behaviour.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    if (accept) rd_data <= mem[rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_fault <= 2'b00;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr  <= req_addr;
        s1_fault <= req_fault;
      end
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RESP_DEPTH; i++) begin
        q_data[i]  <= '0;
        q_addr[i]  <= '0;
        q_fault[i] <= 2'b00;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_data[wr_ptr]  <= (s1_fault != 2'b00) ? '0 : rd_data;
        q_addr[wr_ptr]  <= s1_addr;
        q_fault[wr_ptr] <= s1_fault;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb/tb_imem_fetch_port.sv - directed self-checking bench for imem_fetch_port
module tb_imem_fetch_port;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 1024;
  localparam int IDX_W  = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [ADDR_W-1:0] resp_addr;
  logic [1:0]        resp_fault;
  logic              flush;
  logic              ld_en;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_data;

  int tests = 0;
  int fails = 0;

  imem_fetch_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESP_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_addr(resp_addr), .resp_fault(resp_fault),
    .flush(flush), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge; inputs change after this, checks after a further #1
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] data, input logic [31:0] addr,
                          input logic [1:0] fault);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
    chk({tag, "_data"},  resp_data, data);
    chk({tag, "_addr"},  resp_addr, addr);
    chk({tag, "_fault"}, 32'(resp_fault), 32'(fault));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    flush = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    #12;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data",  resp_data, 32'd0);
    chk("rst_resp_addr",  resp_addr, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_req_ready",  32'(req_ready), 32'd1);
    step();
    rst = 1'b0;

    // program load through the word-write port
    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1; ld_idx = IDX_W'(i); ld_data = 32'h11 * (i + 1);
      step();
    end
    ld_en = 1'b0;

    // 1: back-to-back fetches, latency 2, full throughput
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'd0; #1;
    chk("t1_ready0", 32'(req_ready), 32'd1);
    step(); req_addr = 32'd4; #1;
    chk("t1_ready1", 32'(req_ready), 32'd1);
    chk("t1_lat_not_early", 32'(resp_valid), 32'd0);
    step(); req_addr = 32'd8; #1;
    chk("t1_ready2", 32'(req_ready), 32'd1);
    chk_resp("t1_r0", 32'h11, 32'd0, 2'b00);
    step(); req_addr = 32'd12; #1;
    chk("t1_ready3", 32'(req_ready), 32'd1);
    chk_resp("t1_r1", 32'h22, 32'd4, 2'b00);
    step(); req_valid = 1'b0; #1;
    chk_resp("t1_r2", 32'h33, 32'd8, 2'b00);
    step(); #1;
    chk_resp("t1_r3", 32'h44, 32'd12, 2'b00);
    step(); #1;
    chk("t1_drained", 32'(resp_valid), 32'd0);

    // 2: back-pressure fills the queue, then drains in order
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd0; #1;
    step(); req_addr = 32'd4; #1;
    chk("t2_ready1", 32'(req_ready), 32'd1);
    step(); req_addr = 32'd8; #1;
    chk("t2_ready_full", 32'(req_ready), 32'd0);
    chk_resp("t2_hold0", 32'h11, 32'd0, 2'b00);
    step(); #1;
    chk("t2_ready_full2", 32'(req_ready), 32'd0);
    chk_resp("t2_hold1", 32'h11, 32'd0, 2'b00);
    resp_ready = 1'b1; #1;
    chk("t2_ready_on_pop", 32'(req_ready), 32'd1);
    chk_resp("t2_pop0", 32'h11, 32'd0, 2'b00);
    step(); req_valid = 1'b0; #1;
    chk_resp("t2_pop1", 32'h22, 32'd4, 2'b00);
    step(); #1;
    chk_resp("t2_pop2", 32'h33, 32'd8, 2'b00);
    step(); #1;
    chk("t2_no_dup", 32'(resp_valid), 32'd0);

    // 3: misaligned and out-of-range fetches
    req_valid = 1'b1; req_addr = 32'h6; #1;
    step(); req_valid = 1'b0; #1;
    step(); #1;
    chk_resp("t3_misalign", 32'd0, 32'h6, 2'b01);
    req_valid = 1'b1; req_addr = DEPTH * 4; #1;
    step(); req_valid = 1'b0; #1;
    step(); #1;
    chk_resp("t3_range", 32'd0, DEPTH * 4, 2'b10);
    step(); #1;

    // 4: flush discards in-flight and queued responses
    req_valid = 1'b1; req_addr = 32'd0; #1;
    step(); req_addr = 32'd4; #1;
    step(); req_valid = 1'b0; flush = 1'b1; #1;
    chk("t4_flush_valid", 32'(resp_valid), 32'd0);
    chk("t4_flush_ready", 32'(req_ready), 32'd0);
    step(); flush = 1'b0; req_valid = 1'b1; req_addr = 32'd8; #1;
    chk("t4_post_ready", 32'(req_ready), 32'd1);
    step(); req_valid = 1'b0; #1;
    chk("t4_gone", 32'(resp_valid), 32'd0);
    step(); #1;
    chk_resp("t4_r", 32'h33, 32'd8, 2'b00);
    step(); #1;
    chk("t4_gone2", 32'(resp_valid), 32'd0);

    // 5: load port write collides with fetch of the same word
    ld_en = 1'b1; ld_idx = IDX_W'(1); ld_data = 32'hAA;
    req_valid = 1'b1; req_addr = 32'd4; #1;
    step(); ld_en = 1'b0; req_valid = 1'b0; #1;
    step(); #1;
    chk_resp("t5_old", 32'h22, 32'd4, 2'b00);
    step(); req_valid = 1'b1; req_addr = 32'd4; #1;
    step(); req_valid = 1'b0; #1;
    step(); #1;
    chk_resp("t5_new", 32'hAA, 32'd4, 2'b00);
    step(); #1;

    // 6: reset mid-stream drops the queue but keeps memory
    resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'd0; #1;
    step(); req_addr = 32'd8; #1;
    step(); req_valid = 1'b0; #1;
    step(); #1;
    chk_resp("t6_queued", 32'h11, 32'd0, 2'b00);
    rst = 1'b1; #1;
    chk("t6_rst_valid", 32'(resp_valid), 32'd0);
    chk("t6_rst_data", resp_data, 32'd0);
    step(); rst = 1'b0; resp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'd0; #1;
    chk("t6_ready", 32'(req_ready), 32'd1);
    step(); req_valid = 1'b0; #1;
    chk("t6_no_stale", 32'(resp_valid), 32'd0);
    step(); #1;
    chk_resp("t6_retained", 32'h11, 32'd0, 2'b00);
    step(); #1;
    chk("t6_end", 32'(resp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
